// File: rtl/demod_pkg.sv
// Shared types and arithmetic helpers for the iterative demodulation segment stage.
package demod_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Width of the beat-index counter: at least one bit even for single-beat bursts.
  function automatic int unsigned idx_w(input int unsigned iters);
    return (iters <= 2) ? 1 : $clog2(iters);
  endfunction

  // Add of two words of 'width' bits (width <= 64), carried in 64-bit containers.
  // sat = 0 wraps modulo 2^width; sat = 1 clamps at 2^width-1.
  function automatic logic [63:0] sat_add(input logic [63:0] x,
                                          input logic [63:0] y,
                                          input int unsigned width,
                                          input logic        sat);
    logic [64:0] sum;
    logic [63:0] lim;
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    sum = {1'b0, x} + {1'b0, y};
    if (sat && (sum > {1'b0, lim})) begin
      return lim;
    end
    return sum[63:0] & lim;
  endfunction

endpackage

// File: rtl/demod_seg_iter_add.sv
// Combinational wrapping/saturating adder shared by the address step and the accumulator.
module demod_sat_add
  import demod_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter bit          SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = WIDTH'(sat_add(64'(a_i), 64'(b_i), WIDTH, SAT));

endmodule

// File: rtl/demod_seg_iter.sv
// Accepts a segment base word and emits ITERS address beats a_k = segment + k*STEP
// together with a running accumulator of the addresses emitted so far.
module demod_seg_iter
  import demod_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(65536),
  parameter int unsigned      ITERS = 4,
  parameter bit               SAT   = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       seg_valid,
  output logic                       seg_ready,
  input  logic [WIDTH-1:0]           segment_0,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           a_gen_out,
  output logic [WIDTH-1:0]           demodulated_out,
  output logic [idx_w(ITERS)-1:0]    out_index,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned        IDX_W    = idx_w(ITERS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(ITERS - 1);
  localparam logic               ONE_BEAT = (ITERS == 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic [WIDTH-1:0]   addr_next;
  logic [WIDTH-1:0]   acc_next;
  logic [IDX_W-1:0]   idx_inc;

  // The accumulator adds the already-stepped address, so both adders chain in one cycle.
  demod_sat_add #(.WIDTH(WIDTH), .SAT(SAT)) u_step_add (
    .a_i   (addr_q),
    .b_i   (STEP),
    .sum_o (addr_next)
  );

  demod_sat_add #(.WIDTH(WIDTH), .SAT(SAT)) u_acc_add (
    .a_i   (acc_q),
    .b_i   (addr_next),
    .sum_o (acc_next)
  );

  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (seg_valid) begin
          addr_d  = segment_0;
          acc_d   = segment_0;
          idx_d   = '0;
          last_d  = ONE_BEAT;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            addr_d = addr_next;
            acc_d  = acc_next;
            idx_d  = idx_inc;
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign seg_ready       = (state_q == IDLE);
  assign busy            = (state_q == RUN);
  assign out_valid       = valid_q;
  assign out_last        = last_q;
  assign a_gen_out       = addr_q;
  assign demodulated_out = acc_q;
  assign out_index       = idx_q;

endmodule

// File: tb/tb_demod_seg_iter.sv
// Directed bench for demod_seg_iter: wrap, saturating and single-beat configurations.
module tb_demod_seg_iter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Nominal instance (SAT=0, ITERS=4)
  logic        n_seg_valid, n_seg_ready, n_out_valid, n_out_ready, n_last, n_busy;
  logic [31:0] n_segment, n_a, n_acc;
  logic [1:0]  n_idx;
  // Saturating instance (SAT=1, ITERS=4)
  logic        s_seg_valid, s_seg_ready, s_out_valid, s_out_ready, s_last, s_busy;
  logic [31:0] s_segment, s_a, s_acc;
  logic [1:0]  s_idx;
  // Single-beat instance (ITERS=1)
  logic        o_seg_valid, o_seg_ready, o_out_valid, o_out_ready, o_last, o_busy;
  logic [31:0] o_segment, o_a, o_acc;
  logic [0:0]  o_idx;

  demod_seg_iter #(.WIDTH(32), .STEP(32'h0001_0000), .ITERS(4), .SAT(1'b0)) u_nom (
    .clk(clk), .reset(reset), .seg_valid(n_seg_valid), .seg_ready(n_seg_ready),
    .segment_0(n_segment), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .a_gen_out(n_a), .demodulated_out(n_acc), .out_index(n_idx),
    .out_last(n_last), .busy(n_busy)
  );

  demod_seg_iter #(.WIDTH(32), .STEP(32'h0001_0000), .ITERS(4), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .seg_valid(s_seg_valid), .seg_ready(s_seg_ready),
    .segment_0(s_segment), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .a_gen_out(s_a), .demodulated_out(s_acc), .out_index(s_idx),
    .out_last(s_last), .busy(s_busy)
  );

  demod_seg_iter #(.WIDTH(32), .STEP(32'h0001_0000), .ITERS(1), .SAT(1'b0)) u_one (
    .clk(clk), .reset(reset), .seg_valid(o_seg_valid), .seg_ready(o_seg_ready),
    .segment_0(o_segment), .out_valid(o_out_valid), .out_ready(o_out_ready),
    .a_gen_out(o_a), .demodulated_out(o_acc), .out_index(o_idx),
    .out_last(o_last), .busy(o_busy)
  );

  logic [31:0] nom_a   [4] = '{32'h0000_1000, 32'h0001_1000, 32'h0002_1000, 32'h0003_1000};
  logic [31:0] nom_acc [4] = '{32'h0000_1000, 32'h0001_2000, 32'h0003_3000, 32'h0006_4000};
  logic [31:0] wrp_a   [4] = '{32'hFFFE_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0001_0000};
  logic [31:0] wrp_acc [4] = '{32'hFFFE_0000, 32'hFFFD_0000, 32'hFFFD_0000, 32'hFFFE_0000};
  logic [31:0] sat_a   [4] = '{32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] sat_acc [4] = '{32'hFFFE_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    n_seg_valid = 1'b0; n_segment = '0; n_out_ready = 1'b1;
    s_seg_valid = 1'b0; s_segment = '0; s_out_ready = 1'b1;
    o_seg_valid = 1'b0; o_segment = '0; o_out_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_seg_ready", 32'(n_seg_ready), 32'd1);
    chk("rst_out_valid", 32'(n_out_valid), 32'd0);
    chk("rst_a", n_a, 32'd0);
    chk("rst_acc", n_acc, 32'd0);
    chk("rst_idx", 32'(n_idx), 32'd0);
    chk("rst_last", 32'(n_last), 32'd0);
    chk("rst_busy", 32'(n_busy), 32'd0);
    chk("rst_sat_ready", 32'(s_seg_ready), 32'd1);
    chk("rst_one_ready", 32'(o_seg_ready), 32'd1);
    reset = 1'b0;

    // Nominal burst
    n_seg_valid = 1'b1; n_segment = 32'h0000_1000;
    step();
    n_seg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("nom_a%0d", k), n_a, nom_a[k]);
      chk($sformatf("nom_acc%0d", k), n_acc, nom_acc[k]);
      chk($sformatf("nom_idx%0d", k), 32'(n_idx), 32'(k));
      chk($sformatf("nom_last%0d", k), 32'(n_last), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("nom_valid%0d", k), 32'(n_out_valid), 32'd1);
      chk($sformatf("nom_segrdy%0d", k), 32'(n_seg_ready), 32'd0);
      step();
    end
    chk("nom_end_valid", 32'(n_out_valid), 32'd0);
    chk("nom_end_last", 32'(n_last), 32'd0);
    chk("nom_end_segrdy", 32'(n_seg_ready), 32'd1);
    chk("nom_end_busy", 32'(n_busy), 32'd0);
    chk("nom_end_a_hold", n_a, 32'h0003_1000);
    chk("nom_end_acc_hold", n_acc, 32'h0006_4000);

    // Wrap (SAT=0) and saturation (SAT=1) side by side
    n_seg_valid = 1'b1; n_segment = 32'hFFFE_0000;
    s_seg_valid = 1'b1; s_segment = 32'hFFFE_0000;
    step();
    n_seg_valid = 1'b0; s_seg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_a%0d", k), n_a, wrp_a[k]);
      chk($sformatf("wrap_acc%0d", k), n_acc, wrp_acc[k]);
      chk($sformatf("sat_a%0d", k), s_a, sat_a[k]);
      chk($sformatf("sat_acc%0d", k), s_acc, sat_acc[k]);
      chk($sformatf("sat_idx%0d", k), 32'(s_idx), 32'(k));
      step();
    end
    chk("wrap_end_valid", 32'(n_out_valid), 32'd0);
    chk("sat_end_valid", 32'(s_out_valid), 32'd0);
    chk("sat_end_segrdy", 32'(s_seg_ready), 32'd1);

    // Single-beat burst
    o_seg_valid = 1'b1; o_segment = 32'h0000_0005;
    step();
    o_seg_valid = 1'b0;
    chk("one_a", o_a, 32'h5);
    chk("one_acc", o_acc, 32'h5);
    chk("one_idx", 32'(o_idx), 32'd0);
    chk("one_last", 32'(o_last), 32'd1);
    chk("one_valid", 32'(o_out_valid), 32'd1);
    chk("one_busy", 32'(o_busy), 32'd1);
    step();
    chk("one_end_valid", 32'(o_out_valid), 32'd0);
    chk("one_end_last", 32'(o_last), 32'd0);
    chk("one_end_segrdy", 32'(o_seg_ready), 32'd1);
    chk("one_end_busy", 32'(o_busy), 32'd0);

    // Backpressure on beat 1, with a second segment held off meanwhile
    n_seg_valid = 1'b1; n_segment = 32'h0000_1000;
    step();
    n_segment = 32'h0000_2000;
    chk("bp_beat0_a", n_a, 32'h0000_1000);
    step();
    n_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold_a%0d", c), n_a, 32'h0001_1000);
      chk($sformatf("bp_hold_idx%0d", c), 32'(n_idx), 32'd1);
      chk($sformatf("bp_hold_valid%0d", c), 32'(n_out_valid), 32'd1);
      chk($sformatf("bp_hold_segrdy%0d", c), 32'(n_seg_ready), 32'd0);
      step();
    end
    n_out_ready = 1'b1;
    chk("bp_resume_acc", n_acc, 32'h0001_2000);
    step();
    step();
    chk("bp_beat3_last", 32'(n_last), 32'd1);
    chk("bp_beat3_a", n_a, 32'h0003_1000);
    step();
    chk("bp_bubble_valid", 32'(n_out_valid), 32'd0);
    chk("bp_bubble_segrdy", 32'(n_seg_ready), 32'd1);
    step();
    n_seg_valid = 1'b0;
    chk("seg2_a", n_a, 32'h0000_2000);
    chk("seg2_acc", n_acc, 32'h0000_2000);
    chk("seg2_idx", 32'(n_idx), 32'd0);
    chk("seg2_valid", 32'(n_out_valid), 32'd1);

    // Asynchronous reset during beat 2
    step();
    step();
    chk("pre_rst_idx", 32'(n_idx), 32'd2);
    chk("pre_rst_a", n_a, 32'h0002_2000);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(n_out_valid), 32'd0);
    chk("arst_a", n_a, 32'd0);
    chk("arst_acc", n_acc, 32'd0);
    chk("arst_idx", 32'(n_idx), 32'd0);
    chk("arst_segrdy", 32'(n_seg_ready), 32'd1);
    chk("arst_busy", 32'(n_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_rst_idle", 32'(n_out_valid), 32'd0);
    n_seg_valid = 1'b1; n_segment = 32'h0000_0010;
    step();
    n_seg_valid = 1'b0;
    chk("post_rst_a", n_a, 32'h0000_0010);
    chk("post_rst_acc", n_acc, 32'h0000_0010);
    chk("post_rst_idx", 32'(n_idx), 32'd0);
    chk("post_rst_valid", 32'(n_out_valid), 32'd1);
    repeat (4) step();
    chk("post_rst_end_valid", 32'(n_out_valid), 32'd0);
    chk("post_rst_end_a", n_a, 32'h0003_0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
